// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM write path: command encodings, idle pin
// values and the write sequencer state type.
package sdram_pkg;

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CMD_NOP   = 4'b0111;
   localparam logic [3:0] CMD_ACT   = 4'b0011;
   localparam logic [3:0] CMD_WRITE = 4'b0100;
   localparam logic [3:0] CMD_BST   = 4'b0110;
   localparam logic [3:0] CMD_PRE   = 4'b0010;

   // Wide all-ones patterns, sliced to the bank/address width by users.
   localparam logic [31:0] IDLE_BANK = '1;
   localparam logic [31:0] IDLE_ADDR = '1;
   localparam int          A10_BIT   = 10;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ACT,
      S_TRCD,
      S_WRITE,
      S_DATA,
      S_BST,
      S_TWR,
      S_PRE,
      S_TRP,
      S_END
   } wr_state_t;

endpackage

// File: rtl/sdram_wait_cnt.sv
// Loadable down-counter; done is high whenever the count has reached zero,
// so loading zero makes done true in the very next cycle.
module sdram_wait_cnt #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/sdram_write_seg.sv
// SDRAM write sequencer: splits a linear write request into full-page bursts,
// one per row, each closed with BURST STOP and a precharge.
module sdram_write_seg
   import sdram_pkg::*;
#(
   parameter int DW     = 16,
   parameter int BANK_W = 2,
   parameter int ROW_W  = 13,
   parameter int COL_W  = 9,
   parameter int LEN_W  = 10,
   parameter int T_RCD  = 2,
   parameter int T_WR   = 2,
   parameter int T_RP   = 2
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          init_end,
   input  logic                          wr_en,
   input  logic [BANK_W+ROW_W+COL_W-1:0] wr_addr,
   input  logic [LEN_W-1:0]              wr_len,
   input  logic [DW-1:0]                 wr_data,
   output logic                          wr_ack,
   output logic                          wr_busy,
   output logic                          wr_end,
   output logic [3:0]                    wr_sdram_cmd,
   output logic [BANK_W-1:0]             wr_sdram_bank,
   output logic [ROW_W-1:0]              wr_sdram_addr,
   output logic                          wr_sdram_en,
   output logic [DW-1:0]                 wr_sdram_data
);

   localparam int A_W   = BANK_W + ROW_W + COL_W;
   localparam int CW    = (LEN_W > COL_W + 1) ? LEN_W : COL_W + 1;
   localparam int T_MAX = (T_RCD > T_WR) ? ((T_RCD > T_RP) ? T_RCD : T_RP)
                                         : ((T_WR > T_RP) ? T_WR : T_RP);
   localparam int CNT_W = $clog2(T_MAX + 1);
   localparam logic [ROW_W-1:0] PRE_ADDR = ROW_W'(1) << A10_BIT;

   wr_state_t         state;
   logic [A_W-1:0]    cur_addr;
   logic [LEN_W-1:0]  remain;
   logic [LEN_W-1:0]  seg_len;
   logic [LEN_W-1:0]  seg_left;

   logic [COL_W-1:0]  cur_col;
   logic [ROW_W-1:0]  cur_row;
   logic [BANK_W-1:0] cur_bank;
   logic [CW-1:0]     room;
   logic [CW-1:0]     seg;

   logic              accept, into_write, go_bst, go_pre, go_act;
   logic              cnt_load, cnt_done;
   logic [CNT_W-1:0]  cnt_val;

   assign cur_col  = cur_addr[COL_W-1:0];
   assign cur_row  = cur_addr[COL_W +: ROW_W];
   assign cur_bank = cur_addr[COL_W+ROW_W +: BANK_W];

   // Words left in the current page bound the burst length.
   always_comb begin
      room = CW'(2 ** COL_W) - CW'(cur_col);
      seg  = (CW'(remain) < room) ? CW'(remain) : room;
   end

   always_comb begin
      accept     = (state == S_IDLE) && wr_en && init_end && (wr_len != '0);
      into_write = ((state == S_ACT) || (state == S_TRCD)) && cnt_done;
      go_bst     = ((state == S_WRITE) || (state == S_DATA)) && (seg_left <= LEN_W'(1));
      go_pre     = ((state == S_BST) || (state == S_TWR)) && cnt_done;
      go_act     = ((state == S_PRE) || (state == S_TRP)) && cnt_done && (remain != '0);
      cnt_load   = accept || go_bst || go_pre || go_act;
      if (go_bst) begin
         cnt_val = CNT_W'(T_WR - 1);
      end else if (go_pre) begin
         cnt_val = CNT_W'(T_RP - 1);
      end else begin
         cnt_val = CNT_W'(T_RCD - 1);
      end
      // Pop one word per cycle ahead of the edge that puts it on DQ.
      wr_ack = into_write ||
               (((state == S_WRITE) || (state == S_DATA)) && (seg_left > LEN_W'(1)));
   end

   sdram_wait_cnt #(
      .W (CNT_W)
   ) u_wait_cnt (
      .clk      (clk),
      .rstn     (rstn),
      .load     (cnt_load),
      .load_val (cnt_val),
      .done     (cnt_done)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state         <= S_IDLE;
         cur_addr      <= '0;
         remain        <= '0;
         seg_len       <= '0;
         seg_left      <= '0;
         wr_busy       <= 1'b0;
         wr_end        <= 1'b0;
         wr_sdram_cmd  <= CMD_NOP;
         wr_sdram_bank <= IDLE_BANK[BANK_W-1:0];
         wr_sdram_addr <= IDLE_ADDR[ROW_W-1:0];
         wr_sdram_en   <= 1'b0;
         wr_sdram_data <= '0;
      end else begin
         wr_sdram_cmd  <= CMD_NOP;
         wr_sdram_bank <= IDLE_BANK[BANK_W-1:0];
         wr_sdram_addr <= IDLE_ADDR[ROW_W-1:0];
         wr_sdram_en   <= wr_ack;
         wr_sdram_data <= wr_ack ? wr_data : '0;
         wr_end        <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state         <= S_ACT;
                  cur_addr      <= wr_addr;
                  remain        <= wr_len;
                  wr_busy       <= 1'b1;
                  wr_sdram_cmd  <= CMD_ACT;
                  wr_sdram_bank <= wr_addr[COL_W+ROW_W +: BANK_W];
                  wr_sdram_addr <= wr_addr[COL_W +: ROW_W];
               end
            end
            S_ACT, S_TRCD: begin
               if (into_write) begin
                  state         <= S_WRITE;
                  seg_len       <= LEN_W'(seg);
                  seg_left      <= LEN_W'(seg);
                  wr_sdram_cmd  <= CMD_WRITE;
                  wr_sdram_bank <= cur_bank;
                  wr_sdram_addr <= ROW_W'(cur_col);
               end else begin
                  state <= S_TRCD;
               end
            end
            S_WRITE, S_DATA: begin
               if (go_bst) begin
                  state        <= S_BST;
                  wr_sdram_cmd <= CMD_BST;
               end else begin
                  state    <= S_DATA;
                  seg_left <= seg_left - 1'b1;
               end
            end
            S_BST, S_TWR: begin
               // PRE still names the bank just written; the address advances on the same edge.
               if (go_pre) begin
                  state         <= S_PRE;
                  remain        <= remain - seg_len;
                  cur_addr      <= cur_addr + A_W'(seg_len);
                  wr_sdram_cmd  <= CMD_PRE;
                  wr_sdram_bank <= cur_bank;
                  wr_sdram_addr <= PRE_ADDR;
               end else begin
                  state <= S_TWR;
               end
            end
            S_PRE, S_TRP: begin
               if (go_act) begin
                  state         <= S_ACT;
                  wr_sdram_cmd  <= CMD_ACT;
                  wr_sdram_bank <= cur_bank;
                  wr_sdram_addr <= cur_row;
               end else if (cnt_done) begin
                  state  <= S_END;
                  wr_end <= 1'b1;
               end else begin
                  state <= S_TRP;
               end
            end
            S_END: begin
               state   <= S_IDLE;
               wr_busy <= 1'b0;
            end
            default: begin
               state   <= S_IDLE;
               wr_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_write_seg.sv
// Scoreboard bench for sdram_write_seg: a reference model queues the expected
// command/data events per request and each observed event is popped and compared.
module tb_sdram_write_seg;

   localparam int T_RCD = 2;
   localparam int T_WR  = 2;
   localparam int T_RP  = 2;

   localparam logic [3:0]  NOP   = 4'b0111;
   localparam logic [3:0]  ACT   = 4'b0011;
   localparam logic [3:0]  WRT   = 4'b0100;
   localparam logic [3:0]  BST   = 4'b0110;
   localparam logic [3:0]  PRE   = 4'b0010;
   localparam logic [1:0]  IBANK = 2'b11;
   localparam logic [12:0] IADDR = 13'h1FFF;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        init_end = 1'b0;
   logic        wr_en = 1'b0;
   logic [23:0] wr_addr = '0;
   logic [9:0]  wr_len = '0;
   logic [15:0] wr_data;
   logic        wr_ack, wr_busy, wr_end;
   logic [3:0]  wr_sdram_cmd;
   logic [1:0]  wr_sdram_bank;
   logic [12:0] wr_sdram_addr;
   logic        wr_sdram_en;
   logic [15:0] wr_sdram_data;

   typedef struct {
      int          t;
      logic [3:0]  cmd;
      logic [1:0]  bank;
      logic [12:0] addr;
      logic        en;
      logic [15:0] data;
      logic        fin;
   } ev_t;

   ev_t         exp_q[$];
   int          tests = 0;
   int          fails = 0;
   int          ack_total = 0;
   logic [15:0] data_base = '0;

   always #5 clk = ~clk;

   always @(posedge clk) if (wr_ack === 1'b1) ack_total <= ack_total + 1;
   assign wr_data = data_base + 16'(ack_total);

   sdram_write_seg dut (
      .clk           (clk),
      .rstn          (rstn),
      .init_end      (init_end),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_len        (wr_len),
      .wr_data       (wr_data),
      .wr_ack        (wr_ack),
      .wr_busy       (wr_busy),
      .wr_end        (wr_end),
      .wr_sdram_cmd  (wr_sdram_cmd),
      .wr_sdram_bank (wr_sdram_bank),
      .wr_sdram_addr (wr_sdram_addr),
      .wr_sdram_en   (wr_sdram_en),
      .wr_sdram_data (wr_sdram_data)
   );

   function automatic logic is_idle();
      return (wr_sdram_cmd === NOP) && (wr_sdram_bank === IBANK) && (wr_sdram_addr === IADDR) &&
             (wr_sdram_en === 1'b0) && (wr_sdram_data === 16'h0) && (wr_busy === 1'b0) &&
             (wr_end === 1'b0);
   endfunction

   task automatic push_ev(input int t, input logic [3:0] cmd, input logic [1:0] bank,
                          input logic [12:0] addr, input logic en, input logic [15:0] data,
                          input logic fin);
      ev_t e;
      e.t = t; e.cmd = cmd; e.bank = bank; e.addr = addr; e.en = en; e.data = data; e.fin = fin;
      exp_q.push_back(e);
   endtask

   // Reference model: cycle 1 is the first cycle after the sampling edge.
   task automatic build_expect(input logic [23:0] a, input int len, input logic [15:0] first);
      int          t = 1;
      int          rem = len;
      int          idx = 0;
      int          seg, col, tb;
      logic [23:0] cur = a;
      while (rem > 0) begin
         col = int'(cur[8:0]);
         seg = (rem < 512 - col) ? rem : 512 - col;
         push_ev(t, ACT, cur[23:22], cur[21:9], 1'b0, 16'h0, 1'b0);
         for (int i = 0; i < seg; i++) begin
            if (i == 0) push_ev(t + T_RCD, WRT, cur[23:22], {4'b0, cur[8:0]}, 1'b1, first + 16'(idx), 1'b0);
            else        push_ev(t + T_RCD + i, NOP, IBANK, IADDR, 1'b1, first + 16'(idx), 1'b0);
            idx++;
         end
         tb = t + T_RCD + seg;
         push_ev(tb, BST, IBANK, IADDR, 1'b0, 16'h0, 1'b0);
         push_ev(tb + T_WR, PRE, cur[23:22], 13'h0400, 1'b0, 16'h0, 1'b0);
         t   = tb + T_WR + T_RP;
         rem = rem - seg;
         cur = cur + 24'(seg);
      end
      push_ev(t, NOP, IBANK, IADDR, 1'b0, 16'h0, 1'b1);
   endtask

   task automatic run_request(input string name, input logic [23:0] a, input int len,
                              input logic [15:0] first, input bit pulse_busy);
      int  start;
      int  end_k = -1;
      int  nev = 0;
      ev_t e;
      @(negedge clk);
      start     = ack_total;
      data_base = first - 16'(start);
      build_expect(a, len, first);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_len  = 10'(len);
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         wr_en = 1'b0;
         if (pulse_busy && k >= 2 && k <= 8) begin
            wr_en   = 1'b1;
            wr_addr = ~a;
            wr_len  = 10'd3;
         end
         if (end_k >= 0 && k == end_k + 1) begin
            tests++;
            if (wr_busy !== 1'b0) begin
               fails++;
               $display("FAIL %s busy_fall: wr_busy=%b one cycle after wr_end, expected 0", name, wr_busy);
            end
         end
         if (wr_sdram_cmd !== NOP || wr_sdram_en !== 1'b0 || wr_end !== 1'b0) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL %s unexpected_event: t=%0d cmd=%b bank=%0d addr=%h en=%b data=%h end=%b, expected none",
                        name, k, wr_sdram_cmd, wr_sdram_bank, wr_sdram_addr, wr_sdram_en, wr_sdram_data, wr_end);
            end else begin
               e = exp_q.pop_front();
               if (k != e.t || wr_sdram_cmd !== e.cmd || wr_sdram_bank !== e.bank ||
                   wr_sdram_addr !== e.addr || wr_sdram_en !== e.en || wr_sdram_data !== e.data ||
                   wr_end !== e.fin || wr_busy !== 1'b1) begin
                  fails++;
                  $display("FAIL %s event%0d: got t=%0d cmd=%b bank=%0d addr=%h en=%b data=%h end=%b busy=%b, expected t=%0d cmd=%b bank=%0d addr=%h en=%b data=%h end=%b busy=1",
                           name, nev, k, wr_sdram_cmd, wr_sdram_bank, wr_sdram_addr, wr_sdram_en,
                           wr_sdram_data, wr_end, wr_busy, e.t, e.cmd, e.bank, e.addr, e.en, e.data, e.fin);
               end
               if (e.fin) end_k = k;
            end
            nev++;
         end
         if (exp_q.size() == 0 && end_k >= 0 && k > end_k + 3) break;
      end
      wr_en = 1'b0;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s missing_events: %0d expected events never seen, expected 0", name, exp_q.size());
         exp_q.delete();
      end
      tests++;
      if (ack_total - start != len) begin
         fails++;
         $display("FAIL %s ack_count: got %0d wr_ack pulses, expected %0d", name, ack_total - start, len);
      end
      $display("[TB] request %s addr=%h len=%0d events=%0d acks=%0d", name, a, len, nev, ack_total - start);
   endtask

   task automatic test_reset();
      rstn = 1'b0; init_end = 1'b0; wr_en = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if (!is_idle() || wr_ack !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: cmd=%b bank=%b addr=%h en=%b data=%h busy=%b end=%b ack=%b, expected 0111/11/1fff/0/0000/0/0/0",
                  wr_sdram_cmd, wr_sdram_bank, wr_sdram_addr, wr_sdram_en, wr_sdram_data, wr_busy, wr_end, wr_ack);
      end
      rstn = 1'b1;
      @(negedge clk);
      $display("[TB] reset checked");
   endtask

   task automatic idle_window(input string name);
      int  start = ack_total;
      bit  bad = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (!is_idle()) bad = 1'b1;
      end
      tests++;
      if (bad || ack_total != start) begin
         fails++;
         $display("FAIL %s: outputs left idle=%b acks=%0d, expected idle throughout and 0 acks",
                  name, !bad, ack_total - start);
      end
      $display("[TB] reject %s checked", name);
   endtask

   task automatic test_reject();
      @(negedge clk);
      init_end = 1'b0; wr_en = 1'b1; wr_addr = 24'h012345; wr_len = 10'd4;
      idle_window("no_init");
      init_end = 1'b1; wr_len = 10'd0;
      idle_window("zero_len");
      wr_en = 1'b0; wr_len = 10'd4;
   endtask

   task automatic test_reset_mid();
      bit seen = 1'b0;
      int start;
      @(negedge clk);
      data_base = 16'h5000;
      wr_en = 1'b1; wr_addr = {2'd2, 13'd100, 9'd0}; wr_len = 10'd8;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         wr_en = 1'b0;
         if (wr_sdram_en === 1'b1) seen = 1'b1;
      end
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL reset_mid_reach: data phase not reached within 20 cycles, expected wr_sdram_en=1");
      end
      rstn = 1'b0;
      @(negedge clk);
      tests++;
      if (!is_idle()) begin
         fails++;
         $display("FAIL reset_mid_state: cmd=%b bank=%b addr=%h en=%b busy=%b end=%b, expected 0111/11/1fff/0/0/0",
                  wr_sdram_cmd, wr_sdram_bank, wr_sdram_addr, wr_sdram_en, wr_busy, wr_end);
      end
      rstn = 1'b1;
      start = ack_total;
      idle_window("after_reset");
      $display("[TB] reset mid-burst checked");
   endtask

   initial begin
      test_reset();
      init_end = 1'b1;
      run_request("basic",      {2'd1, 13'd5, 9'd0},        4, 16'h00A0, 1'b0);
      run_request("page_cross", {2'd0, 13'd7, 9'd510},      5, 16'h1100, 1'b0);
      run_request("mem_wrap",   {2'd3, 13'd8191, 9'd511},   2, 16'h2200, 1'b0);
      run_request("single",     {2'd2, 13'd40, 9'd17},      1, 16'h3300, 1'b0);
      test_reject();
      run_request("busy_ignore", {2'd1, 13'd9, 9'd100},     4, 16'h4400, 1'b1);
      test_reset_mid();
      run_request("after_reset", {2'd0, 13'd3, 9'd508},     6, 16'h6600, 1'b0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish within 200000 time units");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sdram_write_seg.md
# sdram_write_seg

Parametrised SDRAM write engine: second-generation write sequencer between the arbiter and the SDRAM command/data pins. Accepts one request of 1..2^LEN_W-1 words at a linear word address. Issues full-page bursts terminated by BURST STOP. Splits transfers transparently at row (page) boundaries, with precharge/activate of the next row, and honours tRCD, tWR and tRP as parameters.

## Interface
- DW, 16, data width
- BANK_W, 2, bank address bits
- ROW_W, 13, row bits (= SDRAM address pins); ROW_W ≥ 11
- COL_W, 9, column bits; COL_W ≤ 10
- LEN_W, 10, request length bits
- T_RCD, 2, ACT→WRITE spacing in cycles, ≥ 1
- T_WR, 2, cycles from BST to PRE, ≥ 1
- T_RP, 2, PRE→next ACT / end spacing in cycles, ≥ 1
- clk  in  1  clock; single clock domain
- rstn  in  1  reset; synchronous, active-low
- init_end  in  1  SDRAM initialisation done
- wr_en  in  1  request strobe; sampled only in IDLE
- wr_addr  in  BANK_W+ROW_W+COL_W  start address {bank,row,col}
- wr_len  in  LEN_W  word count
- wr_data  in  DW  write word; valid in the cycle wr_ack is high
- wr_ack  out  1  combinational data pop; exactly wr_len pulses per request
- wr_busy  out  1  request in progress (state ≠ IDLE)
- wr_end  out  1  one-cycle completion pulse
- wr_sdram_cmd  out  4  {cs_n,ras_n,cas_n,we_n}
- wr_sdram_bank  out  BANK_W  bank address
- wr_sdram_addr  out  ROW_W  SDRAM address pins
- wr_sdram_en  out  1  drive DQ
- wr_sdram_data  out  DW  DQ value

## Operation
- Commands: NOP 0111, ACT 0011, WRITE 0100, BST 0110, PRE 0010.
- Reset/idle values: cmd NOP, bank all-ones, addr all-ones, en 0, data 0, wr_ack/wr_busy/wr_end 0.
- States: IDLE → ACT → TRCD → WRITE → DATA → BST → TWR → PRE → TRP → (ACT if words remain, else END) → IDLE.
- IDLE accepts a request only when wr_en=1, init_end=1 and wr_len≠0. On acceptance, latch address into cur_addr and wr_len into remain. Otherwise stay in IDLE; no outputs change.
- Segment length: seg = min(remain, 2^COL_W − col). Compute at COL_W+1 bits; compare at max(LEN_W, COL_W+1) bits.
- ACT drives bank, row. WRITE drives bank, {0…, col} with A10=0. PRE drives bank, A10=1, other bits 0. All other cycles drive NOP/all-ones.
- After a segment: remain −= seg; cur_addr += seg modulo 2^(BANK_W+ROW_W+COL_W). The next segment therefore starts at col 0 of the next row, carrying into the bank, and wraps the top of memory to 0.
- wr_en during busy is ignored; wr_addr/wr_len changes after acceptance are ignored.
- Synchronous reset in any state: next edge returns to IDLE with reset output values. No wr_end is produced; the in-flight burst is abandoned.

## Timing
- All SDRAM outputs are registered. wr_ack is high in cycle n−1 for each word driven in cycle n. wr_sdram_en is wr_ack delayed one cycle; wr_sdram_data is wr_data registered when wr_ack=1, else 0.
- Cycle 0 = edge where the request is sampled. ACT is visible cycle 1.
- WRITE and first data word are visible at ACT+T_RCD. Words are contiguous, one per cycle, seg cycles.
- BST is visible at last word+1. PRE is visible at BST+T_WR.
- Next-segment ACT or the wr_end pulse occurs at PRE+T_RP. wr_busy falls the cycle after wr_end.
- A new request can be sampled the cycle after wr_end.
- seg=1: WRITE cycle carries the only word; BST follows immediately.

## Structure
- Package sdram_pkg: command encodings, idle bank/addr constants, state enum typedef.
- One sub-module, sdram_wait_cnt: loadable down-counter with done flag. It is shared by TRCD, TWR and TRP waits and loaded with T_x−1 on state entry.
- Segment/address arithmetic and the FSM stay in the top.

## Test plan
Default parameters throughout.
- Basic write: bank 1, row 5, col 0, len 4, data A0..A3.
  - ACT (bank 1, addr 5) at t; WRITE col 0 at t+2; A0..A3 on t+2..t+5 with en=1.
  - BST at t+6; PRE (A10=1) at t+8; wr_end at t+10; exactly 4 wr_ack pulses.
- Page crossing: row 7, col 510, len 5.
  - Segment 1: WRITE col 510, 2 words, BST, PRE.
  - Segment 2: ACT row 8, WRITE col 0, 3 words.
  - 5 acks total; single wr_end.
- Memory wrap: bank 3, row 8191, col 511, len 2. Second segment ACT is bank 0, row 0; WRITE col 0.
- Rejection: each of these leaves outputs idle and wr_ack silent:
  - wr_en with init_end=0;
  - wr_len=0;
  - wr_en pulses while busy.
- Single word: len 1 → WRITE with word, then BST the next cycle, PRE 2 cycles later.
- Reset mid-burst: rstn=0 during DATA. The next edge shows cmd NOP, bank 3, addr 1FFF, en 0, busy 0, and no wr_end; a fresh request then completes normally.
